// File: rtl/prod_acc_pkg.sv
// prod_acc_pkg: shared definitions for the product accumulator.
//   state_t           - accumulator FSM state encoding
//   DEF_IN_WORD_SIZE  - default product input width
//   DEF_ACC_WORD_SIZE - default accumulator / result width
package prod_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam int unsigned DEF_IN_WORD_SIZE  = 16;
  localparam int unsigned DEF_ACC_WORD_SIZE = 20;

endpackage

// File: rtl/prod_acc_sat_add.sv
// sat_add: unsigned W-bit adder that saturates to all-ones on carry-out.
//   a, b : operands
//   sum  : a + b, or 2^W-1 when the true sum does not fit in W bits
//   ovf  : carry-out of the W-bit addition
module sat_add #(
  parameter int unsigned W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    ovf  = full[W];
    sum  = full[W] ? '1 : full[W-1:0];
  end

endmodule

// File: rtl/prod_acc.sv
// prod_acc: accumulates LEN unsigned products per frame with saturation
// and presents the registered frame sum under a valid/ready handshake.
//   clk, reset           - clock, asynchronous active-low reset
//   pin, pin_valid       - product input and its valid
//   in_ready             - block can accept pin this cycle
//   clear                - synchronous abort of the frame being built
//   acc_out, acc_valid   - completed frame sum and its valid
//   acc_ready            - downstream consumes acc_out
//   ovf                  - saturation occurred in the presented frame
module prod_acc
  import prod_acc_pkg::*;
#(
  parameter int unsigned IN_WORD_SIZE  = DEF_IN_WORD_SIZE,
  parameter int unsigned ACC_WORD_SIZE = DEF_ACC_WORD_SIZE,
  parameter int unsigned LEN           = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IN_WORD_SIZE-1:0]  pin,
  input  logic                     pin_valid,
  output logic                     in_ready,
  input  logic                     clear,
  output logic [ACC_WORD_SIZE-1:0] acc_out,
  output logic                     acc_valid,
  input  logic                     acc_ready,
  output logic                     ovf
);

  localparam logic [7:0] LAST = 8'(LEN - 1);

  state_t                   state;
  logic [7:0]               cnt;
  logic [ACC_WORD_SIZE-1:0] acc;
  logic                     sticky;

  logic                     beat;
  logic                     first;
  logic [ACC_WORD_SIZE-1:0] add_a;
  logic [ACC_WORD_SIZE-1:0] pin_ext;
  logic [ACC_WORD_SIZE-1:0] sum;
  logic                     add_ovf;
  logic                     ovf_next;

  assign in_ready = (state != HOLD) | acc_ready;

  // A beat coinciding with clear is dropped in every state.
  always_comb begin
    beat     = pin_valid & in_ready & ~clear;
    first    = (state != ACC);
    pin_ext  = ACC_WORD_SIZE'(pin);
    // The first beat of a frame loads pin by adding it to zero, so the one
    // adder serves both load and accumulate; zero + pin never carries.
    add_a    = first ? '0 : acc;
    ovf_next = add_ovf | (sticky & ~first);
  end

  // Once saturated, acc is all-ones, so any further add either carries
  // (re-saturates) or adds zero: saturation persists without extra logic.
  sat_add #(.W(ACC_WORD_SIZE)) u_sat_add (
    .a   (add_a),
    .b   (pin_ext),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      sticky    <= 1'b0;
      acc_out   <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
    end else if (clear && state != HOLD) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      sticky <= 1'b0;
    end else if (beat) begin
      if (cnt == LAST) begin
        acc_out   <= sum;
        ovf       <= ovf_next;
        acc_valid <= 1'b1;
        state     <= HOLD;
        cnt       <= '0;
        acc       <= '0;
        sticky    <= 1'b0;
      end else begin
        acc       <= sum;
        sticky    <= ovf_next;
        cnt       <= cnt + 8'd1;
        acc_valid <= 1'b0;
        state     <= ACC;
      end
    end else if (state == HOLD && acc_ready) begin
      acc_valid <= 1'b0;
      state     <= IDLE;
    end
  end

endmodule

// File: tb/tb_prod_acc.sv
module tb_prod_acc;

  logic        clk;
  logic        reset;

  logic [15:0] pin;
  logic        pin_valid;
  logic        clear;
  logic        acc_ready;
  logic        in_ready;
  logic [19:0] acc_out;
  logic        acc_valid;
  logic        ovf;

  logic [15:0] b_pin;
  logic        b_pin_valid;
  logic        b_clear;
  logic        b_acc_ready;
  logic        b_in_ready;
  logic [17:0] b_acc_out;
  logic        b_acc_valid;
  logic        b_ovf;

  logic [15:0] c_pin;
  logic        c_pin_valid;
  logic        c_clear;
  logic        c_acc_ready;
  logic        c_in_ready;
  logic [19:0] c_acc_out;
  logic        c_acc_valid;
  logic        c_ovf;

  int errors = 0;
  int checks = 0;

  prod_acc dut (
    .clk(clk), .reset(reset), .pin(pin), .pin_valid(pin_valid),
    .in_ready(in_ready), .clear(clear), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .ovf(ovf)
  );

  prod_acc #(.ACC_WORD_SIZE(18)) dut18 (
    .clk(clk), .reset(reset), .pin(b_pin), .pin_valid(b_pin_valid),
    .in_ready(b_in_ready), .clear(b_clear), .acc_out(b_acc_out),
    .acc_valid(b_acc_valid), .acc_ready(b_acc_ready), .ovf(b_ovf)
  );

  prod_acc #(.LEN(1)) dut1 (
    .clk(clk), .reset(reset), .pin(c_pin), .pin_valid(c_pin_valid),
    .in_ready(c_in_ready), .clear(c_clear), .acc_out(c_acc_out),
    .acc_valid(c_acc_valid), .acc_ready(c_acc_ready), .ovf(c_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if (acc_out !== 20'd0 || acc_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: acc_out=%0d acc_valid=%b ovf=%b, want 0/0/0",
               acc_out, acc_valid, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    logic [15:0] v [8] = '{16'd5000, 16'd1200, 16'd220, 16'd342,
                           16'd1309, 16'd4455, 16'd3220, 16'd1431};
    acc_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pin = v[i];
      pin_valid = 1'b1;
      tick();
      if (i < 7) begin
        checks++;
        if (acc_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_early_valid: beat %0d acc_valid=%b want 0", i, acc_valid);
        end
      end
    end
    pin_valid = 1'b0;
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 20'd17177 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL stream_result: valid=%b acc_out=%0d ovf=%b, want 1/17177/0",
               acc_valid, acc_out, ovf);
    end
    tick();
    checks++;
    if (acc_valid !== 1'b0 || acc_out !== 20'd17177) begin
      errors++;
      $display("FAIL stream_one_cycle: valid=%b acc_out=%0d, want 0/17177",
               acc_valid, acc_out);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] v [8] = '{16'd5000, 16'd1200, 16'd220, 16'd342,
                           16'd1309, 16'd4455, 16'd3220, 16'd1431};
    acc_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pin = v[i];
      pin_valid = 1'b1;
      tick();
    end
    // Offer a new beat of 100 while the result is stalled.
    pin = 16'd100;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0 || acc_valid !== 1'b1 || acc_out !== 20'd17177 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d in_ready=%b valid=%b acc_out=%0d ovf=%b, want 0/1/17177/0",
                 i, in_ready, acc_valid, acc_out, ovf);
      end
      tick();
    end
    acc_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_in_ready_comb: got %b want 1", in_ready);
    end
    tick();
    checks++;
    if (acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_consumed: acc_valid=%b want 0", acc_valid);
    end
    pin = 16'd1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i < 6) begin
        checks++;
        if (acc_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_early_valid: beat %0d acc_valid=%b want 0", i, acc_valid);
        end
      end
    end
    pin_valid = 1'b0;
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 20'd107) begin
      errors++;
      $display("FAIL bp_next_frame: valid=%b acc_out=%0d, want 1/107", acc_valid, acc_out);
    end
    tick();
  endtask

  task automatic test_saturation();
    b_acc_ready = 1'b1;
    b_pin = 16'd65535;
    b_pin_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (b_acc_valid !== 1'b1 || b_acc_out !== 18'd262143 || b_ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_result: valid=%b acc_out=%0d ovf=%b, want 1/262143/1",
               b_acc_valid, b_acc_out, b_ovf);
    end
    b_pin = 16'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (b_acc_valid !== 1'b0 || b_acc_out !== 18'd262143 || b_ovf !== 1'b1) begin
          errors++;
          $display("FAIL sat_held: valid=%b acc_out=%0d ovf=%b, want 0/262143/1",
                   b_acc_valid, b_acc_out, b_ovf);
        end
      end
    end
    b_pin_valid = 1'b0;
    checks++;
    if (b_acc_valid !== 1'b1 || b_acc_out !== 18'd8 || b_ovf !== 1'b0) begin
      errors++;
      $display("FAIL sat_next_frame: valid=%b acc_out=%0d ovf=%b, want 1/8/0",
               b_acc_valid, b_acc_out, b_ovf);
    end
    tick();
  endtask

  task automatic test_clear();
    acc_ready = 1'b1;
    pin = 16'd1000;
    pin_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    pin = 16'd10;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 6) begin
        checks++;
        if (acc_valid !== 1'b0) begin
          errors++;
          $display("FAIL clear_early_valid: acc_valid=%b want 0", acc_valid);
        end
      end
    end
    pin_valid = 1'b0;
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 20'd80 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL clear_result: valid=%b acc_out=%0d ovf=%b, want 1/80/0",
               acc_valid, acc_out, ovf);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    acc_ready = 1'b1;
    pin = 16'd7;
    pin_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    pin_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (acc_out !== 20'd0 || acc_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: acc_out=%0d valid=%b ovf=%b, want 0/0/0",
               acc_out, acc_valid, ovf);
    end
    tick();
    reset = 1'b1;
    pin = 16'd2;
    pin_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    pin_valid = 1'b0;
    checks++;
    if (acc_valid !== 1'b1 || acc_out !== 20'd16 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: valid=%b acc_out=%0d ovf=%b, want 1/16/0",
               acc_valid, acc_out, ovf);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] v [3] = '{16'd7, 16'd9, 16'd11};
    c_acc_ready = 1'b1;
    c_pin_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c_pin = v[i];
      tick();
      checks++;
      if (c_acc_valid !== 1'b1 || c_acc_out !== 20'(v[i]) || c_ovf !== 1'b0) begin
        errors++;
        $display("FAIL len1_beat%0d: valid=%b acc_out=%0d ovf=%b, want 1/%0d/0",
                 i, c_acc_valid, c_acc_out, c_ovf, v[i]);
      end
    end
    c_pin_valid = 1'b0;
    tick();
    checks++;
    if (c_acc_valid !== 1'b0 || c_acc_out !== 20'd11) begin
      errors++;
      $display("FAIL len1_drain: valid=%b acc_out=%0d, want 0/11", c_acc_valid, c_acc_out);
    end
  endtask

  initial begin
    pin = '0;   pin_valid = 1'b0;   clear = 1'b0;   acc_ready = 1'b1;
    b_pin = '0; b_pin_valid = 1'b0; b_clear = 1'b0; b_acc_ready = 1'b1;
    c_pin = '0; c_pin_valid = 1'b0; c_clear = 1'b0; c_acc_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_saturation();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
